// File: rtl/default_slave.sv
// AXI4 decode-error slave: completes any unmapped write or read with DECERR so the master never stalls.
// Write (AW/W/B) and read (AR/R) channels are independent FSMs, one outstanding transaction each.
//
// state  | meaning
// W_IDLE | AWREADY high, waiting for a write address
// W_DATA | WREADY high, draining write beats until WLAST
// W_RESP | BVALID high with DECERR, waiting for BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID high, returning ARLEN+1 zero beats with DECERR

module default_slave #(
  parameter int ID_W   = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   AWID,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY
);

  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t         w_state;
  r_state_t         r_state;
  logic [LEN_W-1:0] cnt;

  // Write burst length and data carry no information for an error response.
  logic unused_inputs;
  assign unused_inputs = ^{AWLEN, WDATA};

  assign RDATA = '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b1;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: if (AWVALID && AWREADY) begin
          BID     <= AWID;
          AWREADY <= 1'b0;
          WREADY  <= 1'b1;
          w_state <= W_DATA;
        end
        W_DATA: if (WVALID && WREADY && WLAST) begin
          WREADY  <= 1'b0;
          BVALID  <= 1'b1;
          BRESP   <= DECERR;
          w_state <= W_RESP;
        end
        W_RESP: if (BVALID && BREADY) begin
          BVALID  <= 1'b0;
          AWREADY <= 1'b1;
          w_state <= W_IDLE;
        end
        default: begin
          AWREADY <= 1'b1;
          WREADY  <= 1'b0;
          BVALID  <= 1'b0;
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  // RLAST is registered one beat ahead: it rises when the counter is about to reach zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RRESP   <= 2'b00;
      cnt     <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (ARVALID && ARREADY) begin
          RID     <= ARID;
          cnt     <= ARLEN;
          RLAST   <= (ARLEN == '0);
          RRESP   <= DECERR;
          RVALID  <= 1'b1;
          ARREADY <= 1'b0;
          r_state <= R_DATA;
        end
        R_DATA: if (RVALID && RREADY) begin
          if (RLAST) begin
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            ARREADY <= 1'b1;
            r_state <= R_IDLE;
          end else begin
            cnt   <= cnt - 1'b1;
            RLAST <= (cnt == LEN_W'(1));
          end
        end
        default: begin
          RVALID  <= 1'b0;
          RLAST   <= 1'b0;
          ARREADY <= 1'b1;
          r_state <= R_IDLE;
        end
      endcase
    end
  end

endmodule
